// File: rtl/chacha20_poly1305_tag_verify_pkg.sv
// Shared constants, FSM encoding and helpers for the Poly1305 receive-side tag checker.
package chacha_poly_pkg;

   localparam logic [129:0] P1305 = 130'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
   localparam logic [127:0] R_CLAMP_MASK = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StWaitBlk = 3'd1,
      StMul     = 3'd2,
      StRed     = 3'd3,
      StFinal   = 3'd4,
      StCmp     = 3'd5
   } state_e;

   // 2^130 == 5 mod p; acc < 2^130 and m < 2^129 keep the folded value inside 130 bits
   function automatic logic [129:0] fold_sum(input logic [130:0] sum);
      return sum[130] ? (sum[129:0] + 130'd5) : sum[129:0];
   endfunction

endpackage

// File: rtl/chacha20_poly1305_tag_verify_if.sv
// Control, key/tag and ciphertext-block signals between the RX path and the tag checker.
interface chacha20_poly1305_tag_verify_if;
   logic         start;
   logic [127:0] r_in;
   logic [127:0] s_in;
   logic [127:0] tag_in;
   logic         blk_valid;
   logic         blk_ready;
   logic [127:0] blk_data;
   logic [4:0]   blk_bytes;
   logic         blk_last;
   logic         busy;
   logic         done;
   logic         tag_ok;
   logic [127:0] tag_out;

   modport master (
      output start, r_in, s_in, tag_in, blk_valid, blk_data, blk_bytes, blk_last,
      input  blk_ready, busy, done, tag_ok, tag_out
   );

   modport slave (
      input  start, r_in, s_in, tag_in, blk_valid, blk_data, blk_bytes, blk_last,
      output blk_ready, busy, done, tag_ok, tag_out
   );
endinterface

// File: rtl/chacha20_poly1305_tag_verify_block_pad.sv
// Builds the Poly1305 block value: bytes beyond blk_bytes masked, pad bit at 8*blk_bytes.
module poly1305_block_pad (
   input  logic [127:0] blk_data,
   input  logic [4:0]   blk_bytes,
   output logic [128:0] m
);
   always_comb begin
      m = '0;
      for (int i = 0; i < 16; i++) begin
         if (5'(i) < blk_bytes) m[8*i +: 8] = blk_data[8*i +: 8];
      end
      if (blk_bytes <= 5'd16) m[{blk_bytes, 3'b000}] = 1'b1;
   end
endmodule

// File: rtl/chacha20_poly1305_tag_verify_mult.sv
// 130x128 multiplier, one 32-bit limb of b per cycle; done pulses with product valid.
module mult_130x128_limb (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [129:0] a,
   input  logic [127:0] b,
   output logic         done,
   output logic [257:0] product
);
   logic [129:0] a_q;
   logic [127:0] b_q;
   logic [1:0]   cnt_q;
   logic         run_q;
   logic         done_q;
   logic [257:0] prod_q;
   logic [31:0]  limb;
   logic [161:0] pp;
   logic [257:0] pp_shift;

   always_comb begin
      limb     = b_q[32*cnt_q +: 32];
      pp       = {32'b0, a_q} * {130'b0, limb};
      pp_shift = {96'b0, pp} << {cnt_q, 5'b00000};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q    <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
         prod_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            a_q    <= a;
            b_q    <= b;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            prod_q <= '0;
         end else if (run_q) begin
            prod_q <= prod_q + pp_shift;
            cnt_q  <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done    = done_q;
   assign product = prod_q;
endmodule

// File: rtl/chacha20_poly1305_tag_verify_reduce.sv
// Partial reduction of a 258-bit product mod 2^130-5 to a value below 2^130.
module reduce_mod_poly1305 (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [257:0] value_in,
   output logic         done,
   output logic [129:0] value_out
);
   logic [131:0] t_d;
   logic [131:0] t_q;
   logic         vld_q;
   logic [4:0]   k;
   logic [130:0] t2;

   always_comb begin
      t_d = {2'b0, value_in[129:0]} + {2'b0, value_in[257:130], 2'b00}
          + {4'b0, value_in[257:130]};
      k   = {1'b0, t_q[131:130], 2'b00} + {3'b0, t_q[131:130]};
      t2  = {1'b0, t_q[129:0]} + {126'b0, k};
      value_out = t2[129:0] + {127'b0, t2[130], 1'b0, t2[130]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t_q   <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= start;
         if (start) t_q <= t_d;
      end
   end

   assign done = vld_q;
endmodule

// File: rtl/chacha20_poly1305_tag_verify.sv
// Poly1305 tag computation over received ciphertext blocks with constant-time tag compare.
module chacha20_poly1305_tag_verify
   import chacha_poly_pkg::*;
#(
   parameter bit CLAMP_R = 1'b1
) (
   input logic                          clk,
   input logic                          reset_n,
   chacha20_poly1305_tag_verify_if.slave bus
);
   state_e       state_q, state_d;
   logic [127:0] r_q, s_q, tag_q, tag_out_q;
   logic [129:0] acc_q, mul_a_q;
   logic         last_q, mul_go_q, tag_ok_q;

   logic         hs, diff, mul_done, red_start, red_done;
   logic [128:0] blk_m;
   logic [130:0] sum;
   logic [129:0] acc_final, red_value;
   logic [127:0] tag_sum;
   logic [257:0] product;

   poly1305_block_pad u_pad (
      .blk_data  (bus.blk_data),
      .blk_bytes (bus.blk_bytes),
      .m         (blk_m)
   );

   mult_130x128_limb u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_go_q),
      .a       (mul_a_q),
      .b       (r_q),
      .done    (mul_done),
      .product (product)
   );

   reduce_mod_poly1305 u_red (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (red_start),
      .value_in  (product),
      .done      (red_done),
      .value_out (red_value)
   );

   always_comb begin
      hs        = bus.blk_valid && (state_q == StWaitBlk);
      sum       = {1'b0, acc_q} + {2'b0, blk_m};
      red_start = (state_q == StMul) && mul_done;
      acc_final = (acc_q >= P1305) ? (acc_q - P1305) : acc_q;
      tag_sum   = acc_final[127:0] + s_q;
      // full-width reduce, no early exit on first differing bit
      diff      = |(tag_out_q ^ tag_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (bus.start) state_d = StWaitBlk;
         StWaitBlk: if (hs) state_d = (bus.blk_bytes == 5'd0) ? StFinal : StMul;
         StMul:     if (mul_done) state_d = StRed;
         StRed:     if (red_done) state_d = last_q ? StFinal : StWaitBlk;
         StFinal:   state_d = StCmp;
         StCmp:     state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.blk_ready = (state_q == StWaitBlk);
      bus.busy      = (state_q != StIdle);
      bus.done      = (state_q == StCmp);
      bus.tag_ok    = (state_q == StCmp) ? ~diff : tag_ok_q;
      bus.tag_out   = tag_out_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q       <= '0;
         s_q       <= '0;
         tag_q     <= '0;
         acc_q     <= '0;
         mul_a_q   <= '0;
         last_q    <= 1'b0;
         mul_go_q  <= 1'b0;
         tag_out_q <= '0;
         tag_ok_q  <= 1'b0;
      end else begin
         mul_go_q <= 1'b0;
         if (state_q == StIdle && bus.start) begin
            r_q       <= CLAMP_R ? (bus.r_in & R_CLAMP_MASK) : bus.r_in;
            s_q       <= bus.s_in;
            tag_q     <= bus.tag_in;
            acc_q     <= '0;
            last_q    <= 1'b0;
            tag_out_q <= '0;
            tag_ok_q  <= 1'b0;
         end
         if (hs && bus.blk_bytes != 5'd0) begin
            mul_a_q  <= fold_sum(sum);
            mul_go_q <= 1'b1;
            last_q   <= bus.blk_last;
         end
         if (state_q == StRed && red_done) acc_q <= red_value;
         if (state_q == StFinal) begin
            acc_q     <= acc_final;
            tag_out_q <= tag_sum;
         end
         if (state_q == StCmp) tag_ok_q <= ~diff;
      end
   end
endmodule
